// File: rtl/md_pkg.sv
//------------------------------------------------------------------------------
// Module : md_pkg
// Brief  : Op codes, FSM state encoding and op-class helpers for md_unit.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package md_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;
    localparam logic [3:0] OP_MFHI  = 4'd11;
    localparam logic [3:0] OP_MFLO  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    function automatic logic is_mult(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_md(input logic [3:0] op);
        return is_mult(op) || is_div(op);
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_arith.sv
//------------------------------------------------------------------------------
// Module : md_arith
// Brief  : Combinational multiply / accumulate / divide datapath for md_unit.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] rhi_o,
    output logic [WIDTH-1:0] rlo_o,
    output logic             zero_o
);

    localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic                 w_sgn;
    logic [2*WIDTH-1:0]   w_ax;
    logic [2*WIDTH-1:0]   w_bx;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_acc;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic                 w_ovf;
    logic [WIDTH-1:0]     w_amag;
    logic [WIDTH-1:0]     w_bmag;
    logic [WIDTH-1:0]     w_q;
    logic [WIDTH-1:0]     w_r;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_sgn  = (op_i == OP_MULT) || (op_i == OP_MADD) ||
                    (op_i == OP_MSUB) || (op_i == OP_DIV);
    assign zero_o = (b_i == '0);

    // Sign-extend to full width so one unsigned multiplier serves both signednesses.
    assign w_ax   = w_sgn ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
    assign w_bx   = w_sgn ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
    assign w_prod = w_ax * w_bx;
    assign w_acc  = {hi_i, lo_i};

    // Divide on magnitudes, then restore signs; a zero divisor is replaced to keep the divider defined.
    assign w_a_neg = w_sgn & a_i[WIDTH-1];
    assign w_b_neg = w_sgn & b_i[WIDTH-1];
    assign w_ovf   = w_sgn && (a_i == C_MIN) && (b_i == '1);
    assign w_amag  = w_a_neg ? -a_i : a_i;
    assign w_bmag  = zero_o ? C_ONE : (w_b_neg ? -b_i : b_i);
    assign w_q     = w_amag / w_bmag;
    assign w_r     = w_amag % w_bmag;
    assign w_quo   = w_ovf ? C_MIN : ((w_a_neg ^ w_b_neg) ? -w_q : w_q);
    assign w_rem   = w_ovf ? '0    : (w_a_neg ? -w_r : w_r);

    always_comb begin
        {rhi_o, rlo_o} = w_acc;
        case (op_i)
            OP_MULT, OP_MULTU: {rhi_o, rlo_o} = w_prod;
            OP_MADD, OP_MADDU: {rhi_o, rlo_o} = w_acc + w_prod;
            OP_MSUB, OP_MSUBU: {rhi_o, rlo_o} = w_acc - w_prod;
            OP_DIV,  OP_DIVU : begin
                if (!zero_o) begin
                    {rhi_o, rlo_o} = {w_rem, w_quo};
                end
            end
            default: {rhi_o, rlo_o} = w_acc;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
//------------------------------------------------------------------------------
// Module : md_unit
// Brief  : Multi-cycle MIPS multiply/divide unit with HI/LO, flush and div0.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);

    md_state_e        state_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] rhi_q;
    logic [WIDTH-1:0] rlo_q;
    logic             dz_q;
    logic             div0_q;

    logic [WIDTH-1:0] w_rhi;
    logic [WIDTH-1:0] w_rlo;
    logic             w_zero;
    logic [CW-1:0]    w_last;

    md_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op_i   (op),
        .a_i    (a),
        .b_i    (b),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .rhi_o  (w_rhi),
        .rlo_o  (w_rlo),
        .zero_o (w_zero)
    );

    assign w_last = (state_q == ST_MUL) ? MUL_LAST : DIV_LAST;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            rhi_q   <= '0;
            rlo_q   <= '0;
            dz_q    <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            div0_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !flush) begin
                        if (is_md(op)) begin
                            state_q <= is_div(op) ? ST_DIV : ST_MUL;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            rhi_q   <= w_rhi;
                            rlo_q   <= w_rlo;
                            dz_q    <= is_div(op) & w_zero;
                        end else if (op == OP_MTHI) begin
                            hi_q <= a;
                        end else if (op == OP_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                default: begin
                    // Flush wins over completion so an aborted op never commits.
                    if (flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == w_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        div0_q  <= dz_q;
                        if (!dz_q) begin
                            hi_q <= rhi_q;
                            lo_q <= rlo_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        out = '0;
        case (op)
            OP_MFHI: out = hi_q;
            OP_MFLO: out = lo_q;
            default: out = '0;
        endcase
    end

    assign busy      = busy_q;
    assign stall_req = busy_q | (start & is_md(op) & ~flush);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign div0      = div0_q;

endmodule

`default_nettype wire
